difo_buffer: RTL and testbench
==============================

# difo_buffer

Parametrised, mode-selectable data buffer that succeeds the fixed single-mode stack. It stores up to DEPTH words and operates as either a FIFO or a LIFO, selected at run time. Both sides use valid/ready handshakes, and the block reports live occupancy. It sits between a producer and a consumer in the datapath, wherever the team previously instantiated a stack or a queue.

## Interface
- DATA_BITS, 32, word width (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- PTR_BITS, $clog2(DEPTH), pointer width (derived; do not override)
- CNT_BITS, $clog2(DEPTH)+1, occupancy width (derived; do not override)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clr_i  in  1  synchronous clear; same effect as reset on control state
- mode_i  in  1  0 = FIFO, 1 = LIFO; sampled only while empty
- in_valid_i  in  1  producer has a word
- in_ready_o  out  1  buffer can accept a word
- in_data_i  in  DATA_BITS  write data
- out_valid_o  out  1  buffer holds a word
- out_ready_i  in  1  consumer takes the word
- out_data_o  out  DATA_BITS  show-ahead read data
- count_o  out  CNT_BITS  current occupancy, 0..DEPTH
- mode_o  out  1  mode currently in force
- ovf_o  out  1  sticky overflow flag (see Configuration)
- udf_o  out  1  sticky underflow flag (see Configuration)

## Operation
- Handshake events:
  - push = in_valid_i & in_ready_o.
  - pop = out_valid_o & out_ready_i.
- Output qualifiers:
  - in_ready_o = (count != DEPTH).
  - out_valid_o = (count != 0).
- State:
  - wr_ptr, rd_ptr: PTR_BITS each, wrap modulo DEPTH.
  - count: CNT_BITS.
  - mode_q: 1 bit.
  - Storage array is not reset.
- Mode latch: mode_q <= mode_i on any cycle where count==0 and no push occurs. Otherwise mode_q holds, so a mode change while non-empty is ignored until the buffer drains.
- FIFO mode:
  - push writes mem[wr_ptr] and increments wr_ptr.
  - pop increments rd_ptr.
  - out_data_o = mem[rd_ptr].
- LIFO mode:
  - wr_ptr is the top-of-stack pointer and rd_ptr is unused.
  - push writes mem[wr_ptr] and increments wr_ptr.
  - pop decrements wr_ptr.
  - out_data_o = mem[wr_ptr-1].
- Simultaneous push and pop:
  - FIFO: both pointers advance; count unchanged.
  - LIFO: replace-top. in_data_i is written to mem[wr_ptr-1]; wr_ptr and count are unchanged; the popped word is the old top.
- Full: in_ready_o is low, so no push is accepted even if a pop occurs in the same cycle (no pass-through).
- Empty: out_valid_o is low and out_data_o is driven to 0.
- count: +1 on push only, −1 on pop only, unchanged otherwise.
- clr_i has priority over push and pop: pointers, count and flags go to 0; mode_q <= mode_i.

## Timing
- Reset values:
  - in_ready_o = 1, out_valid_o = 0, count_o = 0, out_data_o = 0.
  - ovf_o = 0, udf_o = 0.
  - mode_o = 0 (FIFO).
- A word pushed at edge N is visible on out_data_o with out_valid_o high after edge N (1-cycle latency).
- count_o, in_ready_o and out_valid_o update in the cycle after the event; they are derived from registered state.
- out_data_o is combinational from the array and pointers.
- Reset asserted mid-transfer clears all control state immediately; stored data is lost.
- No combinational path from in_valid_i to in_ready_o, or from out_ready_i to out_valid_o.

## Configuration
- DIFO_ERR_FLAGS_EN defined:
  - ovf_o is set when in_valid_i & ~in_ready_o.
  - udf_o is set when out_ready_i & ~out_valid_o.
  - Both are sticky until rst or clr_i.
- DIFO_ERR_FLAGS_EN undefined: ovf_o and udf_o are tied to 0 and no flag registers are built.

## Test plan
- FIFO, DEPTH=4: push 0x11,0x22,0x33,0x44 -> count_o=4, in_ready_o=0; pop four -> outputs 0x11,0x22,0x33,0x44, then out_valid_o=0, out_data_o=0.
- LIFO, DEPTH=4: push 0xA,0xB,0xC -> pops return 0xC,0xB,0xA; count_o steps 3,2,1,0.
- LIFO replace: stack holding 0x5,0x6, then push 0x7 with pop in the same cycle -> popped 0x6, count_o stays 2, next out_data_o=0x7.
- FIFO wrap: 10 interleaved push/pop pairs with DEPTH=4 -> in-order data, pointers wrap, count_o stays 1.
- Mode: set mode_i=1 while count=2 in FIFO -> mode_o stays 0 until drained, then becomes 1; clr_i with count=3 -> count_o=0 next cycle.
- With DIFO_ERR_FLAGS_EN: push while full -> ovf_o=1 and held; pop while empty -> udf_o=1; rst -> both 0.

Source files
------------

// File: rtl/difo_buffer_if.sv
// Handshake bundle for difo_buffer: producer-side and consumer-side valid/ready/data.
// The slave modport is the buffer; the master modport is the producer/consumer pair.
interface difo_buffer_if #(
    parameter int DATA_BITS = 32
);
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [DATA_BITS-1:0] in_data_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [DATA_BITS-1:0] out_data_o;

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o
    );

    modport master (
        output in_valid_i,
        output in_data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o
    );
endinterface

// File: rtl/difo_buffer.sv
// Run-time selectable FIFO/LIFO buffer with valid/ready handshakes and live occupancy.
// Define DIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module difo_buffer #(
    parameter int DATA_BITS = 32,
    parameter int DEPTH     = 8,
    parameter int PTR_BITS  = $clog2(DEPTH),
    parameter int CNT_BITS  = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                mode_i,
    difo_buffer_if.slave        bus,
    output logic [CNT_BITS-1:0] count_o,
    output logic                mode_o,
    output logic                ovf_o,
    output logic                udf_o
);
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                mode_q, mode_d;

    logic                push, pop, empty;
    logic [PTR_BITS-1:0] top_ptr;
    logic [PTR_BITS-1:0] wr_addr;
    logic                wr_en;

    assign empty           = (count_q == '0);
    assign bus.in_ready_o  = (count_q != FULL_CNT);
    assign bus.out_valid_o = ~empty;
    assign push            = bus.in_valid_i & bus.in_ready_o;
    assign pop             = bus.out_valid_o & bus.out_ready_i;
    assign top_ptr         = wr_ptr_q - PTR_BITS'(1);

    // A LIFO push+pop overwrites the current top in place instead of growing the stack.
    assign wr_addr = (mode_q & pop) ? top_ptr : wr_ptr_q;
    assign wr_en   = push & ~clr_i;

    assign bus.out_data_o = empty  ? '0 :
                            mode_q ? mem[top_ptr] : mem[rd_ptr_q];

    assign count_o = count_q;
    assign mode_o  = mode_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mode_d   = mode_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            mode_d   = mode_i;
        end else begin
            if (mode_q) begin
                if (push & ~pop) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
                if (pop & ~push) wr_ptr_d = top_ptr;
            end else begin
                if (push) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
                if (pop)  rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
            end
            if (push & ~pop) count_d = count_q + CNT_BITS'(1);
            if (pop & ~push) count_d = count_q - CNT_BITS'(1);
            // Idle-while-empty: take the new mode and realign the read pointer,
            // since LIFO operation leaves rd_ptr stale.
            if (empty & ~push) begin
                mode_d   = mode_i;
                rd_ptr_d = wr_ptr_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mode_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= bus.in_data_i;
    end

`ifdef DIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q | (bus.in_valid_i & ~bus.in_ready_o);
        udf_d = udf_q | (bus.out_ready_i & ~bus.out_valid_o);
        if (clr_i) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf_o = ovf_q;
    assign udf_o = udf_q;
`else
    assign ovf_o = 1'b0;
    assign udf_o = 1'b0;
`endif
endmodule

// File: tb/tb_difo_buffer.sv
// Randomized and directed bench for difo_buffer (DEPTH=4), checked against a queue-based model.
// Flag expectations follow DIFO_ERR_FLAGS_EN when it is defined for the build.
module tb_difo_buffer;
    localparam int DATA_BITS = 16;
    localparam int DEPTH     = 4;
    localparam int CNT_BITS  = $clog2(DEPTH) + 1;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                clr_i = 1'b0;
    logic                mode_i = 1'b0;
    logic [CNT_BITS-1:0] count_o;
    logic                mode_o, ovf_o, udf_o;

    int checks = 0;
    int errors = 0;

    logic [DATA_BITS-1:0] model_q[$];
    bit                   model_mode;
    bit                   model_ovf, model_udf;

    difo_buffer_if #(.DATA_BITS(DATA_BITS)) bus ();

    difo_buffer #(.DATA_BITS(DATA_BITS), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr_i),
        .mode_i  (mode_i),
        .bus     (bus),
        .count_o (count_o),
        .mode_o  (mode_o),
        .ovf_o   (ovf_o),
        .udf_o   (udf_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        logic [DATA_BITS-1:0] exp_data;
        int sz;
        sz = model_q.size();
        exp_data = (sz == 0) ? '0 : (model_mode ? model_q[sz-1] : model_q[0]);
        checkOutput("count", 32'(count_o), 32'(sz));
        checkOutput("in_ready", 32'(bus.in_ready_o), 32'(sz != DEPTH));
        checkOutput("out_valid", 32'(bus.out_valid_o), 32'(sz != 0));
        checkOutput("out_data", 32'(bus.out_data_o), 32'(exp_data));
        checkOutput("mode", 32'(mode_o), 32'(model_mode));
`ifdef DIFO_ERR_FLAGS_EN
        checkOutput("ovf", 32'(ovf_o), 32'(model_ovf));
        checkOutput("udf", 32'(udf_o), 32'(model_udf));
`else
        checkOutput("ovf", 32'(ovf_o), 32'd0);
        checkOutput("udf", 32'(udf_o), 32'd0);
`endif
    endtask

    // Behavioural rules: FIFO pops the oldest word, LIFO pops the newest; pop before push
    // so a LIFO push+pop naturally replaces the top.
    task automatic modelStep(input bit v, input logic [DATA_BITS-1:0] d, input bit r, input bit m, input bit c);
        bit can_push, can_pop, push, pop;
        int sz;
        sz = model_q.size();
        can_push = (sz != DEPTH);
        can_pop  = (sz != 0);
        push = v && can_push;
        pop  = r && can_pop;
        if (c) begin
            model_q.delete();
            model_mode = m;
            model_ovf  = 0;
            model_udf  = 0;
            return;
        end
        if (v && !can_push) model_ovf = 1;
        if (r && !can_pop)  model_udf = 1;
        if (pop) begin
            if (model_mode) void'(model_q.pop_back());
            else            void'(model_q.pop_front());
        end
        if (push) model_q.push_back(d);
        if (sz == 0 && !push) model_mode = m;
    endtask

    task automatic applyStimulus(input bit v, input logic [DATA_BITS-1:0] d, input bit r, input bit m, input bit c);
        bus.in_valid_i  = v;
        bus.in_data_i   = d;
        bus.out_ready_i = r;
        mode_i          = m;
        clr_i           = c;
        checkAll();
        @(posedge clk);
        modelStep(v, d, r, m, c);
        @(negedge clk);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_q.delete();
        model_mode = 0;
        model_ovf  = 0;
        model_udf  = 0;
        checkAll();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b0;
        applyReset();

        // FIFO fill, overflow attempt, drain, underflow attempt
        applyStimulus(1, 16'h11, 0, 0, 0);
        applyStimulus(1, 16'h22, 0, 0, 0);
        applyStimulus(1, 16'h33, 0, 0, 0);
        applyStimulus(1, 16'h44, 0, 0, 0);
        applyStimulus(1, 16'h55, 0, 0, 0);
        applyStimulus(0, 16'h0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 16'h0, 1, 0, 0);
        applyStimulus(0, 16'h0, 1, 0, 0);
        applyStimulus(0, 16'h0, 0, 0, 0);
        applyReset();
        applyStimulus(0, 16'h0, 0, 0, 0);

        // LIFO push/pop and replace-top
        applyStimulus(0, 16'h0, 0, 1, 0);
        applyStimulus(1, 16'hA, 0, 1, 0);
        applyStimulus(1, 16'hB, 0, 1, 0);
        applyStimulus(1, 16'hC, 0, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 16'h0, 1, 1, 0);
        applyStimulus(1, 16'h5, 0, 1, 0);
        applyStimulus(1, 16'h6, 0, 1, 0);
        applyStimulus(1, 16'h7, 1, 1, 0);
        applyStimulus(0, 16'h0, 1, 1, 0);
        applyStimulus(0, 16'h0, 1, 1, 0);

        // Back to FIFO, mode change ignored while non-empty, clear with data held
        applyStimulus(0, 16'h0, 0, 0, 0);
        applyStimulus(1, 16'h101, 0, 1, 0);
        applyStimulus(1, 16'h102, 0, 1, 0);
        applyStimulus(0, 16'h0, 0, 1, 0);
        applyStimulus(0, 16'h0, 1, 1, 0);
        applyStimulus(0, 16'h0, 1, 1, 0);
        applyStimulus(0, 16'h0, 0, 1, 0);
        applyStimulus(0, 16'h0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 16'(16'h200 + i), 0, 0, 0);
        applyStimulus(0, 16'h0, 0, 0, 1);

        // FIFO wrap with one word resident
        applyStimulus(1, 16'h300, 0, 0, 0);
        for (int i = 1; i <= 10; i++) applyStimulus(1, 16'(16'h300 + i), 1, 0, 0);
        applyStimulus(0, 16'h0, 1, 0, 0);

        // Random traffic with occasional clears, mode requests and one async reset
        begin
            bit rm;
            rm = 0;
            for (int n = 0; n < 600; n++) begin
                if ((n % 16) == 0) rm = 1'($urandom_range(0, 1));
                if (n == 300) applyReset();
                applyStimulus(($urandom_range(0, 99) < 55), 16'($urandom), ($urandom_range(0, 99) < 50),
                              rm, ($urandom_range(0, 39) == 0));
            end
        end
        checkAll();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
